// File: rtl/pep_batch_cmd_unroll.sv
`default_nettype none
// ============================================================================
// Module      : pep_batch_cmd_unroll
// Description : Unrolls a batch command (first PBS slot + PBS count) into a
//               stream of per-PBS issue requests. It tracks the completion of
//               each issued PBS and returns a single acknowledge per batch.
//
// Ports       :
//   clk                 in   1      sole clock, rising edge
//   s_rst_n             in   1      asynchronous active-low reset
//   batch_cmd_vld       in   1      batch command valid
//   batch_cmd_rdy       out  1      batch command ready (IDLE only)
//   batch_cmd_pid_first in   PID_W  first slot of batch
//   batch_cmd_pbs_nb    in   NB_W   PBS count in batch
//   pbs_vld             out  1      per-PBS issue valid
//   pbs_rdy             in   1      per-PBS issue ready
//   pbs_pid             out  PID_W  slot id being issued
//   pbs_gid             out  GID_W  GRAM bank of pbs_pid
//   pbs_last            out  1      last PBS of current batch
//   pbs_done            in   1      pulse: one issued PBS completed
//   batch_ack           out  1      pulse: whole batch completed
//   batch_ack_pbs_nb    out  NB_W   PBS count of acked batch (0 otherwise)
//   busy                out  1      FSM not in IDLE
//   err                 out  2      sticky: [0] illegal cmd, [1] stray done
//
// Revision    : 1.0 - initial release
// ============================================================================
module pep_batch_cmd_unroll #(
    parameter  int BATCH_PBS_NB = 9,
    parameter  int TOTAL_PBS_NB = 27,
    parameter  int GRAM_NB      = 3,
    localparam int PID_W        = $clog2(TOTAL_PBS_NB),
    localparam int NB_W         = $clog2(BATCH_PBS_NB + 1),
    localparam int GID_W        = $clog2(GRAM_NB)
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic             batch_cmd_vld,
    output logic             batch_cmd_rdy,
    input  logic [PID_W-1:0] batch_cmd_pid_first,
    input  logic [NB_W-1:0]  batch_cmd_pbs_nb,
    output logic             pbs_vld,
    input  logic             pbs_rdy,
    output logic [PID_W-1:0] pbs_pid,
    output logic [GID_W-1:0] pbs_gid,
    output logic             pbs_last,
    input  logic             pbs_done,
    output logic             batch_ack,
    output logic [NB_W-1:0]  batch_ack_pbs_nb,
    output logic             busy,
    output logic [1:0]       err
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_ISSUE     = 2'd1;
    localparam logic [1:0] c_WAIT_DONE = 2'd2;
    localparam logic [1:0] c_ACK       = 2'd3;

    localparam logic [PID_W-1:0] c_PID_MAX = PID_W'(TOTAL_PBS_NB - 1);
    localparam logic [PID_W-1:0] c_PID_ONE = PID_W'(1);
    localparam logic [NB_W-1:0]  c_NB_MAX  = NB_W'(BATCH_PBS_NB);
    localparam logic [NB_W-1:0]  c_NB_ONE  = NB_W'(1);

    logic [1:0]       r_state;
    logic [PID_W-1:0] r_pid;        // slot currently offered; walks with wrap
    logic [NB_W-1:0]  r_pbs_nb;
    logic [NB_W-1:0]  r_issue_cnt;
    logic [NB_W-1:0]  r_done_cnt;
    logic [1:0]       r_err;

    logic             w_is_issue;
    logic             w_is_wait;
    logic             w_cmd_legal;
    logic             w_hs;
    logic             w_last;
    logic             w_done_ok;
    logic [NB_W-1:0]  w_done_cnt_nxt;
    logic [PID_W-1:0] w_pid_nxt;
    logic [31:0]      w_pid_ext;
    logic [GID_W-1:0] w_gid;

    assign w_is_issue  = (r_state == c_ISSUE);
    assign w_is_wait   = (r_state == c_WAIT_DONE);

    assign w_cmd_legal = (batch_cmd_pbs_nb != '0) &&
                         (batch_cmd_pbs_nb <= c_NB_MAX) &&
                         (batch_cmd_pid_first <= c_PID_MAX);

    assign w_hs        = w_is_issue && pbs_rdy;
    assign w_last      = (r_issue_cnt == (r_pbs_nb - c_NB_ONE));

    // A completion is only legal while something is outstanding; a PBS whose
    // issue handshake happens this very cycle already counts as outstanding.
    assign w_done_ok      = pbs_done && (w_is_issue || w_is_wait) &&
                            ((r_done_cnt < r_issue_cnt) || w_hs);
    assign w_done_cnt_nxt = w_done_ok ? (r_done_cnt + c_NB_ONE) : r_done_cnt;

    // Running slot id instead of (first + cnt) mod TOTAL: only a compare and
    // an increment are needed on the issue path.
    assign w_pid_nxt = (r_pid == c_PID_MAX) ? '0 : (r_pid + c_PID_ONE);

    assign w_pid_ext = 32'(r_pid);
    assign w_gid     = GID_W'(w_pid_ext % 32'(GRAM_NB));

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state     <= c_IDLE;
            r_pid       <= '0;
            r_pbs_nb    <= '0;
            r_issue_cnt <= '0;
            r_done_cnt  <= '0;
            r_err       <= '0;
        end else begin
            if (pbs_done && !w_done_ok) begin
                r_err[1] <= 1'b1;
            end
            r_done_cnt <= w_done_cnt_nxt;

            case (r_state)
                c_IDLE: begin
                    if (batch_cmd_vld) begin
                        if (w_cmd_legal) begin
                            r_state     <= c_ISSUE;
                            r_pid       <= batch_cmd_pid_first;
                            r_pbs_nb    <= batch_cmd_pbs_nb;
                            r_issue_cnt <= '0;
                            r_done_cnt  <= '0;
                        end else begin
                            // Consumed but dropped; FSM stays idle.
                            r_err[0] <= 1'b1;
                        end
                    end
                end
                c_ISSUE: begin
                    if (w_hs) begin
                        r_issue_cnt <= r_issue_cnt + c_NB_ONE;
                        r_pid       <= w_pid_nxt;
                        if (w_last) begin
                            // Skip WAIT_DONE when the final completion
                            // coincides with the final issue.
                            r_state <= (w_done_cnt_nxt == r_pbs_nb) ? c_ACK
                                                                    : c_WAIT_DONE;
                        end
                    end
                end
                c_WAIT_DONE: begin
                    if (w_done_cnt_nxt == r_pbs_nb) begin
                        r_state <= c_ACK;
                    end
                end
                c_ACK: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign batch_cmd_rdy    = (r_state == c_IDLE);
    assign busy             = (r_state != c_IDLE);
    assign pbs_vld          = w_is_issue;
    assign pbs_pid          = w_is_issue ? r_pid : '0;
    assign pbs_gid          = w_is_issue ? w_gid : '0;
    assign pbs_last         = w_is_issue && w_last;
    assign batch_ack        = (r_state == c_ACK);
    assign batch_ack_pbs_nb = (r_state == c_ACK) ? r_pbs_nb : '0;
    assign err              = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pep_batch_cmd_unroll.sv
`default_nettype none
// ============================================================================
// Module      : tb_pep_batch_cmd_unroll
// Description : Self-checking bench for pep_batch_cmd_unroll. Expected PBS
//               issues and batch acks are queued when a command is driven and
//               compared whenever the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pep_batch_cmd_unroll;

    localparam int BATCH_PBS_NB = 9;
    localparam int TOTAL_PBS_NB = 27;
    localparam int GRAM_NB      = 3;
    localparam int PID_W        = $clog2(TOTAL_PBS_NB);
    localparam int NB_W         = $clog2(BATCH_PBS_NB + 1);
    localparam int GID_W        = $clog2(GRAM_NB);

    logic             clk;
    logic             s_rst_n;
    logic             batch_cmd_vld;
    logic             batch_cmd_rdy;
    logic [PID_W-1:0] batch_cmd_pid_first;
    logic [NB_W-1:0]  batch_cmd_pbs_nb;
    logic             pbs_vld;
    logic             pbs_rdy;
    logic [PID_W-1:0] pbs_pid;
    logic [GID_W-1:0] pbs_gid;
    logic             pbs_last;
    logic             pbs_done;
    logic             batch_ack;
    logic [NB_W-1:0]  batch_ack_pbs_nb;
    logic             busy;
    logic [1:0]       err;

    logic             done_auto;
    logic             done_man;
    logic             auto_done;

    int               tests;
    int               fails;
    int               issued;
    int               sent;
    logic [31:0]      exp_q[$];
    int               ack_q[$];

    assign pbs_done = done_auto | done_man;

    pep_batch_cmd_unroll #(
        .BATCH_PBS_NB (BATCH_PBS_NB),
        .TOTAL_PBS_NB (TOTAL_PBS_NB),
        .GRAM_NB      (GRAM_NB)
    ) dut (
        .clk                 (clk),
        .s_rst_n             (s_rst_n),
        .batch_cmd_vld       (batch_cmd_vld),
        .batch_cmd_rdy       (batch_cmd_rdy),
        .batch_cmd_pid_first (batch_cmd_pid_first),
        .batch_cmd_pbs_nb    (batch_cmd_pbs_nb),
        .pbs_vld             (pbs_vld),
        .pbs_rdy             (pbs_rdy),
        .pbs_pid             (pbs_pid),
        .pbs_gid             (pbs_gid),
        .pbs_last            (pbs_last),
        .pbs_done            (pbs_done),
        .batch_ack           (batch_ack),
        .batch_ack_pbs_nb    (batch_ack_pbs_nb),
        .busy                (busy),
        .err                 (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard checks on the falling edge, then completion
    // pulses are driven just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (s_rst_n) begin
            if (pbs_vld) begin
                if (exp_q.size() == 0) begin
                    chk("pbs_unexpected", 32'(pbs_vld), 32'd0);
                end else begin
                    chk("pbs_item", {19'd0, pbs_pid, pbs_gid, pbs_last}, exp_q[0]);
                    if (pbs_rdy) begin
                        void'(exp_q.pop_front());
                        issued++;
                    end
                end
            end
            if (batch_ack) begin
                if (ack_q.size() == 0) begin
                    chk("ack_unexpected", 32'(batch_ack), 32'd0);
                end else begin
                    chk("ack_nb", 32'(batch_ack_pbs_nb), 32'(ack_q.pop_front()));
                end
                if (auto_done) begin
                    chk("ack_before_all_done", 32'(issued - sent), 32'd0);
                end
            end else begin
                chk("ack_nb_idle_zero", 32'(batch_ack_pbs_nb), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        if (auto_done && s_rst_n && (issued > sent)) begin
            done_auto = 1'b1;
            sent++;
        end else begin
            done_auto = 1'b0;
            if (!auto_done || !s_rst_n) sent = issued;
        end
    endtask

    task automatic send_cmd(input int first, input int nb, input bit legal);
        int n;
        int pid;
        batch_cmd_vld       = 1'b1;
        batch_cmd_pid_first = PID_W'(first);
        batch_cmd_pbs_nb    = NB_W'(nb);
        n = 0;
        while (!batch_cmd_rdy && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_rdy", 32'(batch_cmd_rdy), 32'd1);
        if (legal) begin
            for (int i = 0; i < nb; i++) begin
                pid = (first + i) % TOTAL_PBS_NB;
                exp_q.push_back({19'd0, PID_W'(pid), GID_W'(pid % GRAM_NB), (i == nb - 1)});
            end
            ack_q.push_back(nb);
        end
        tick();
        batch_cmd_vld = 1'b0;
        chk("first_vld_latency", 32'(pbs_vld), 32'(legal));
        chk("busy_after_cmd", 32'(busy), 32'(legal));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0 || ack_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(!busy && exp_q.size() == 0 && ack_q.size() == 0), 32'd1);
    endtask

    initial begin
        int base;
        int n;
        tests               = 0;
        fails               = 0;
        issued              = 0;
        sent                = 0;
        s_rst_n             = 1'b0;
        batch_cmd_vld       = 1'b0;
        batch_cmd_pid_first = '0;
        batch_cmd_pbs_nb    = '0;
        pbs_rdy             = 1'b0;
        done_auto           = 1'b0;
        done_man            = 1'b0;
        auto_done           = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_pbs_vld", 32'(pbs_vld), 32'd0);
        chk("rst_pbs_pid", 32'(pbs_pid), 32'd0);
        chk("rst_pbs_gid", 32'(pbs_gid), 32'd0);
        chk("rst_pbs_last", 32'(pbs_last), 32'd0);
        chk("rst_ack", 32'(batch_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        s_rst_n = 1'b1;
        tick();
        chk("rst_rdy", 32'(batch_cmd_rdy), 32'd1);

        // Full batch from slot 0, completions one cycle after each issue
        pbs_rdy   = 1'b1;
        auto_done = 1'b1;
        send_cmd(0, 9, 1'b1);
        wait_idle("batch9_complete");

        // Slot wrap 26 -> 0
        send_cmd(24, 6, 1'b1);
        wait_idle("wrap_complete");

        // Back-pressure: ready toggles every cycle
        pbs_rdy = 1'b0;
        base    = issued;
        send_cmd(10, 3, 1'b1);
        n = 0;
        while ((busy || exp_q.size() != 0 || ack_q.size() != 0) && n < 60) begin
            pbs_rdy = ~pbs_rdy;
            tick();
            n++;
        end
        chk("stall_complete", 32'(!busy && exp_q.size() == 0 && ack_q.size() == 0), 32'd1);
        chk("stall_issue_count", 32'(issued - base), 32'd3);
        chk("err_clean", 32'(err), 32'd0);

        // Single PBS completing in its own issue cycle
        pbs_rdy   = 1'b1;
        auto_done = 1'b0;
        send_cmd(5, 1, 1'b1);
        done_man = 1'b1;
        tick();
        done_man = 1'b0;
        chk("nb1_ack", 32'(batch_ack), 32'd1);
        chk("nb1_ack_nb", 32'(batch_ack_pbs_nb), 32'd1);
        chk("nb1_no_rdy_in_ack", 32'(batch_cmd_rdy), 32'd0);
        tick();
        chk("nb1_idle", 32'(busy), 32'd0);
        chk("nb1_err", 32'(err), 32'd0);

        // Illegal commands, then a stray completion
        send_cmd(0, 0, 1'b0);
        chk("illegal_nb0_err", 32'(err), 32'd1);
        send_cmd(0, 10, 1'b0);
        chk("illegal_nb10_err", 32'(err), 32'd1);
        send_cmd(27, 9, 1'b0);
        chk("illegal_pid27_err", 32'(err), 32'd1);
        repeat (3) tick();
        done_man = 1'b1;
        tick();
        done_man = 1'b0;
        chk("stray_done_err", 32'(err), 32'd3);
        repeat (2) tick();
        chk("err_sticky", 32'(err), 32'd3);

        // Asynchronous reset in the middle of an issuing batch
        auto_done = 1'b1;
        send_cmd(3, 9, 1'b1);
        repeat (2) tick();
        #3;
        s_rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(pbs_vld), 32'd0);
        chk("mid_rst_pid", 32'(pbs_pid), 32'd0);
        chk("mid_rst_gid", 32'(pbs_gid), 32'd0);
        chk("mid_rst_last", 32'(pbs_last), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ack", 32'(batch_ack), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        exp_q.delete();
        ack_q.delete();
        repeat (2) tick();
        s_rst_n = 1'b1;
        repeat (12) tick();
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_rdy", 32'(batch_cmd_rdy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
